azadi_prog_loader: RTL and testbench

- Boot-programming front end between the caravel pad wrapper and the SoC instruction memory.
- Synchronises and debounces the programming button, receives the program image over UART 8N1 at a runtime bit period, and packs bytes into 32-bit little-endian words.
- Writes each word to instruction memory through a req/gnt handshake and holds the core in reset for the whole load.

---
 rtl/azadi_loader_pkg.sv | 10 +
 rtl/azadi_prog_loader_if.sv | 13 +
 rtl/azadi_uart_rx_byte.sv | 92 +++++++++
 rtl/azadi_prog_loader.sv | 201 ++++++++++++++++++++
 tb/tb_azadi_prog_loader.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/azadi_loader_pkg.sv
// Shared types and constants for the boot-programming loader.
package azadi_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [1:0] {L_IDLE, L_LOAD, L_WRITE, L_DONE} ld_state_e;

endpackage

// File: rtl/azadi_prog_loader_if.sv
// Instruction-memory write port: request/grant handshake with address and data.
interface azadi_prog_loader_if #(
    parameter int ADDR_W = 12
) ();
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic              mem_gnt_i;

    modport master (output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, input mem_gnt_i);
    modport slave  (input mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, output mem_gnt_i);
endinterface

// File: rtl/azadi_uart_rx_byte.sv
// UART 8N1 receiver on an already-synchronised line; one-cycle byte valid and frame-error pulses.
module azadi_uart_rx_byte
    import azadi_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_i,
    input  logic [15:0] clks_per_bit_i,
    output logic [7:0]  byte_o,
    output logic        valid_o,
    output logic        frame_err_o
);

    rx_state_e   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
    logic [15:0] half_cyc;

    assign half_cyc = clks_per_bit_i >> 1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (!rx_i) state_d = RX_START;
            end
            RX_START: begin
                // Re-check mid start bit so a short low glitch is ignored.
                if (cnt_q == half_cyc - 16'd1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_i ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == clks_per_bit_i - 16'd1) begin
                    cnt_d   = '0;
                    shift_d = {rx_i, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'(UART_DATA_BITS - 1)) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == clks_per_bit_i - 16'd1) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    valid_d = rx_i;
                    ferr_d  = !rx_i;
                end
            end
            default: state_d = RX_IDLE;
        endcase
        if (clks_per_bit_i < 16'd2) begin
            state_d = RX_IDLE;
            cnt_d   = '0;
            valid_d = 1'b0;
            ferr_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign byte_o      = shift_q;
    assign valid_o     = valid_q;
    assign frame_err_o = ferr_q;

endmodule

// File: rtl/azadi_prog_loader.sv
// Boot loader: debounced prog button opens a load window, UART bytes are packed
// little-endian into words and written to instruction memory while the core is held in reset.
module azadi_prog_loader
    import azadi_loader_pkg::*;
#(
    parameter int ADDR_W       = 12,
    parameter int DEBOUNCE_CYC = 1000,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 prog_i,
    input  logic                 uart_rx_i,
    input  logic [15:0]          clks_per_bit_i,
    azadi_prog_loader_if.master  mem,
    output logic                 core_rst_o,
    output logic                 load_done_o,
    output logic                 err_o
);

    localparam int CNT_W = $clog2(BYTES_PER_WORD + 1);

    logic [SYNC_STAGES-1:0] prog_sync_q, prog_sync_d, rx_sync_q, rx_sync_d;
    logic                   prog_s, rx_s;

    always_comb begin
        prog_sync_d    = prog_sync_q;
        rx_sync_d      = rx_sync_q;
        prog_sync_d[0] = prog_i;
        rx_sync_d[0]   = uart_rx_i;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            prog_sync_d[i] = prog_sync_q[i-1];
            rx_sync_d[i]   = rx_sync_q[i-1];
        end
    end

    assign prog_s = prog_sync_q[SYNC_STAGES-1];
    assign rx_s   = rx_sync_q[SYNC_STAGES-1];

    logic [15:0] db_cnt_q, db_cnt_d;
    logic        prog_db_q, prog_db_d;
    logic        db_flip, db_rise, db_fall;

    always_comb begin
        db_flip   = 1'b0;
        db_cnt_d  = '0;
        prog_db_d = prog_db_q;
        if (prog_s != prog_db_q) begin
            if (db_cnt_q == 16'(DEBOUNCE_CYC - 1)) begin
                db_flip   = 1'b1;
                prog_db_d = prog_s;
            end else begin
                db_cnt_d = db_cnt_q + 16'd1;
            end
        end
    end

    assign db_rise = db_flip &  prog_s;
    assign db_fall = db_flip & ~prog_s;

    logic [7:0] rx_byte;
    logic       rx_valid, rx_ferr;

    azadi_uart_rx_byte u_rx (
        .clk            (wb_clk_i),
        .rst            (wb_rst_i),
        .rx_i           (rx_s),
        .clks_per_bit_i (clks_per_bit_i),
        .byte_o         (rx_byte),
        .valid_o        (rx_valid),
        .frame_err_o    (rx_ferr)
    );

    logic [7:0] hold_q, hold_d;
    logic       hold_vld_q, hold_vld_d;
    logic       consume, overrun;

    always_comb begin
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q & ~consume;
        overrun    = 1'b0;
        if (rx_valid) begin
            if (hold_vld_q) begin
                overrun = 1'b1;
            end else begin
                hold_d     = rx_byte;
                hold_vld_d = 1'b1;
            end
        end
    end

    ld_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic              req_q, req_d;
    logic              core_rst_q, core_rst_d;
    logic              stop_pend_q, stop_pend_d;
    logic              err_q, err_d;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        byte_cnt_d  = byte_cnt_q;
        req_d       = req_q;
        core_rst_d  = core_rst_q;
        stop_pend_d = stop_pend_q;
        err_d       = err_q;
        consume     = 1'b0;
        unique case (state_q)
            L_IDLE: begin
                consume = hold_vld_q;
                if (db_rise) begin
                    state_d     = L_LOAD;
                    addr_d      = '0;
                    byte_cnt_d  = '0;
                    core_rst_d  = 1'b1;
                    stop_pend_d = 1'b0;
                    err_d       = 1'b0;
                end
            end
            L_LOAD: begin
                if (db_fall) begin
                    state_d = L_DONE;
                    if (byte_cnt_q != '0) err_d = 1'b1;
                end else if (hold_vld_q) begin
                    consume = 1'b1;
                    wdata_d[{byte_cnt_q[1:0], 3'b000} +: 8] = hold_q;
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (byte_cnt_q == CNT_W'(BYTES_PER_WORD - 1)) begin
                        state_d = L_WRITE;
                        req_d   = 1'b1;
                    end
                end
            end
            L_WRITE: begin
                // A release during the write is remembered until the grant lands.
                if (db_fall) stop_pend_d = 1'b1;
                if (mem.mem_gnt_i) begin
                    req_d       = 1'b0;
                    addr_d      = addr_q + 1'b1;
                    byte_cnt_d  = '0;
                    stop_pend_d = 1'b0;
                    if (addr_q == '1) err_d = 1'b1;
                    state_d = (stop_pend_q | db_fall) ? L_DONE : L_LOAD;
                end
            end
            L_DONE: begin
                consume    = hold_vld_q;
                core_rst_d = 1'b0;
                state_d    = L_IDLE;
            end
            default: state_d = L_IDLE;
        endcase
        if (rx_ferr | overrun) err_d = 1'b1;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            prog_sync_q <= '0;
            rx_sync_q   <= '1;
            db_cnt_q    <= '0;
            prog_db_q   <= 1'b0;
            hold_q      <= '0;
            hold_vld_q  <= 1'b0;
            state_q     <= L_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            byte_cnt_q  <= '0;
            req_q       <= 1'b0;
            core_rst_q  <= 1'b0;
            stop_pend_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            prog_sync_q <= prog_sync_d;
            rx_sync_q   <= rx_sync_d;
            db_cnt_q    <= db_cnt_d;
            prog_db_q   <= prog_db_d;
            hold_q      <= hold_d;
            hold_vld_q  <= hold_vld_d;
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            byte_cnt_q  <= byte_cnt_d;
            req_q       <= req_d;
            core_rst_q  <= core_rst_d;
            stop_pend_q <= stop_pend_d;
            err_q       <= err_d;
        end
    end

    assign mem.mem_req_o   = req_q;
    assign mem.mem_we_o    = req_q;
    assign mem.mem_addr_o  = addr_q;
    assign mem.mem_wdata_o = wdata_q;
    assign core_rst_o      = core_rst_q;
    assign load_done_o     = (state_q == L_DONE);
    assign err_o           = err_q;

endmodule

// File: tb/tb_azadi_prog_loader.sv
// Scoreboard bench: expected writes queued by the stimulus, popped by a write monitor.
module tb_azadi_prog_loader;

    localparam int AW  = 2;
    localparam int CPB = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        prog = 1'b0;
    logic        rx = 1'b1;
    logic [15:0] cpb = 16'(CPB);
    logic        core_rst, load_done, err;

    always #5 clk = ~clk;

    azadi_prog_loader_if #(.ADDR_W(AW)) mem ();

    azadi_prog_loader #(.ADDR_W(AW), .DEBOUNCE_CYC(16), .SYNC_STAGES(2)) dut (
        .wb_clk_i       (clk),
        .wb_rst_i       (rst),
        .prog_i         (prog),
        .uart_rx_i      (rx),
        .clks_per_bit_i (cpb),
        .mem            (mem),
        .core_rst_o     (core_rst),
        .load_done_o    (load_done),
        .err_o          (err)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    wr_t exp_q[$];
    wr_t e;
    int  total = 0, bad = 0;
    int  grants = 0, done_cnt = 0, req_len = 0, last_len = 0, gnt_delay = 0;
    int  g0, d0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop_ok;
        tick(CPB);
        rx = 1'b1;
        tick(stop_ok ? 2 : 2 * CPB);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic push(input int a, input logic [31:0] d);
        wr_t x;
        x.a = AW'(a);
        x.d = d;
        exp_q.push_back(x);
    endtask

    // Memory model: grant after gnt_delay request cycles.
    initial begin
        int w;
        w = 0;
        mem.mem_gnt_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (mem.mem_req_o && !mem.mem_gnt_i) begin
                if (w >= gnt_delay) begin
                    mem.mem_gnt_i = 1'b1;
                    w = 0;
                end else begin
                    w++;
                end
            end else begin
                mem.mem_gnt_i = 1'b0;
                w = 0;
            end
        end
    end

    logic          prev_req = 1'b0, prev_gnt = 1'b0;
    logic [AW-1:0] prev_a = '0;
    logic [31:0]   prev_d = '0;

    always @(negedge clk) begin
        if (load_done) done_cnt++;
        if (mem.mem_req_o) begin
            req_len++;
            chk("we_eq_req", 32'(mem.mem_we_o), 32'd1);
            if (prev_req && !prev_gnt) begin
                chk("req_addr_stable", 32'(mem.mem_addr_o), 32'(prev_a));
                chk("req_data_stable", mem.mem_wdata_o, prev_d);
            end
            if (mem.mem_gnt_i) begin
                grants++;
                last_len = req_len;
                req_len  = 0;
                chk("core_rst_in_write", 32'(core_rst), 32'd1);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got addr=%0h data=%h want none",
                             mem.mem_addr_o, mem.mem_wdata_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(mem.mem_addr_o), 32'(e.a));
                    chk("wr_data", mem.mem_wdata_o, e.d);
                end
            end
        end else begin
            req_len = 0;
        end
        prev_req = mem.mem_req_o;
        prev_gnt = mem.mem_gnt_i;
        prev_a   = mem.mem_addr_o;
        prev_d   = mem.mem_wdata_o;
    end

    initial begin
        tick(3);
        chk("rst_req", 32'(mem.mem_req_o), 32'd0);
        chk("rst_addr", 32'(mem.mem_addr_o), 32'd0);
        chk("rst_wdata", mem.mem_wdata_o, 32'd0);
        chk("rst_core_rst", 32'(core_rst), 32'd0);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        tick(2);

        // Two words, immediate grant
        g0 = grants;
        push(0, 32'h12345678);
        push(1, 32'hDEADBEEF);
        prog = 1'b1;
        tick(40);
        chk("s1_core_rst_on", 32'(core_rst), 32'd1);
        send_word(32'h12345678);
        send_word(32'hDEADBEEF);
        tick(6);
        chk("s1_grants", 32'(grants - g0), 32'd2);
        chk("s1_core_rst_held", 32'(core_rst), 32'd1);
        d0 = done_cnt;
        prog = 1'b0;
        tick(40);
        chk("s1_done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("s1_core_rst_off", 32'(core_rst), 32'd0);
        chk("s1_err", 32'(err), 32'd0);

        // Grant delayed by 5 cycles
        gnt_delay = 5;
        g0 = grants;
        push(0, 32'h04030201);
        prog = 1'b1;
        tick(40);
        send_word(32'h04030201);
        tick(12);
        chk("s2_grants", 32'(grants - g0), 32'd1);
        chk("s2_req_len", 32'(last_len), 32'd6);
        chk("s2_addr", 32'(mem.mem_addr_o), 32'd1);
        prog = 1'b0;
        tick(40);
        gnt_delay = 0;

        // Short prog glitch is filtered
        d0 = done_cnt;
        prog = 1'b1;
        tick(10);
        prog = 1'b0;
        tick(5);
        chk("s3_core_rst_mid", 32'(core_rst), 32'd0);
        tick(30);
        chk("s3_core_rst_end", 32'(core_rst), 32'd0);
        chk("s3_done", 32'(done_cnt - d0), 32'd0);
        chk("s3_addr", 32'(mem.mem_addr_o), 32'd1);

        // Bad stop bit drops the second byte
        prog = 1'b1;
        tick(40);
        chk("s4_err_before", 32'(err), 32'd0);
        push(0, 32'h55443311);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        send_byte(8'h55, 1'b1);
        tick(6);
        chk("s4_err", 32'(err), 32'd1);
        chk("s4_addr", 32'(mem.mem_addr_o), 32'd1);
        d0 = done_cnt;
        prog = 1'b0;
        tick(40);
        chk("s4_done", 32'(done_cnt - d0), 32'd1);
        chk("s4_err_sticky", 32'(err), 32'd1);

        // Release after a partial word
        g0 = grants;
        prog = 1'b1;
        tick(40);
        chk("s5_err_cleared", 32'(err), 32'd0);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        d0 = done_cnt;
        prog = 1'b0;
        tick(40);
        chk("s5_no_write", 32'(grants - g0), 32'd0);
        chk("s5_err", 32'(err), 32'd1);
        chk("s5_done", 32'(done_cnt - d0), 32'd1);
        chk("s5_core_rst_off", 32'(core_rst), 32'd0);

        // Five words into a 4-word space wrap to address 0
        g0 = grants;
        prog = 1'b1;
        tick(40);
        for (int i = 0; i < 5; i++) push(i % 4, 32'hA0A00000 | 32'(i));
        for (int i = 0; i < 5; i++) send_word(32'hA0A00000 | 32'(i));
        tick(6);
        chk("s6_grants", 32'(grants - g0), 32'd5);
        chk("s6_wrap_err", 32'(err), 32'd1);
        chk("s6_addr", 32'(mem.mem_addr_o), 32'd1);

        // Reset in the middle of a word
        send_byte(8'h77, 1'b1);
        send_byte(8'h88, 1'b1);
        prog = 1'b0;
        rst = 1'b1;
        tick(1);
        chk("mrst_req", 32'(mem.mem_req_o), 32'd0);
        chk("mrst_we", 32'(mem.mem_we_o), 32'd0);
        chk("mrst_addr", 32'(mem.mem_addr_o), 32'd0);
        chk("mrst_wdata", mem.mem_wdata_o, 32'd0);
        chk("mrst_core_rst", 32'(core_rst), 32'd0);
        chk("mrst_done", 32'(load_done), 32'd0);
        chk("mrst_err", 32'(err), 32'd0);
        rst = 1'b0;
        d0 = done_cnt;
        tick(40);
        chk("post_rst_core_rst", 32'(core_rst), 32'd0);
        chk("post_rst_done", 32'(done_cnt - d0), 32'd0);
        chk("pending_writes", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
